// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a two-entry skid buffer (main + skid).
// Optional perf counters (stall_cnt, flush_cnt) when EX_MEM_PERF_EN is defined.
module ex_mem_skid_reg #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            ram_we_i,
  input  logic [XLEN-1:0] ram_wdata_i,
  input  logic [3:0]      mem_w_wdth_i,
  input  logic            ram_re_i,
  input  logic [5:0]      mem_r_wdth_i,
  input  logic            reg_we_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic [XLEN-1:0] wdate_csr_reg_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic            ram_we_o,
  output logic [XLEN-1:0] ram_wdata_o,
  output logic [3:0]      mem_w_wdth_o,
  output logic            ram_re_o,
  output logic [5:0]      mem_r_wdth_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] wdate_csr_reg_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic            ram_we;
    logic [XLEN-1:0] ram_wdata;
    logic [3:0]      mem_w_wdth;
    logic            ram_re;
    logic [5:0]      mem_r_wdth;
    logic            reg_we;
    logic [4:0]      reg_waddr;
    logic [XLEN-1:0] wdate_csr_reg;
  } ex_mem_t;

  ex_mem_t in_b;
  ex_mem_t main_q, main_d;
  ex_mem_t skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    accept;

  always_comb begin
    in_b.pc            = pc_i;
    in_b.alu_result    = alu_result_i;
    in_b.ram_we        = ram_we_i;
    in_b.ram_wdata     = ram_wdata_i;
    in_b.mem_w_wdth    = mem_w_wdth_i;
    in_b.ram_re        = ram_re_i;
    in_b.mem_r_wdth    = mem_r_wdth_i;
    in_b.reg_we        = reg_we_i;
    in_b.reg_waddr     = reg_waddr_i;
    in_b.wdate_csr_reg = wdate_csr_reg_i;
  end

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    unique case (1'b1)
      flush: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
      (!flush && skid_valid_q): begin
        if (out_ready) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end
      end
      default: begin
        if (!main_valid_q || out_ready) begin
          if (accept) begin
            main_d = in_b;
          end
          main_valid_d = accept;
        end else if (accept) begin
          skid_d       = in_b;
          skid_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid       = main_valid_q;
  assign pc_o            = main_q.pc;
  assign alu_result_o    = main_q.alu_result;
  assign ram_wdata_o     = main_q.ram_wdata;
  assign mem_w_wdth_o    = main_q.mem_w_wdth;
  assign mem_r_wdth_o    = main_q.mem_r_wdth;
  assign reg_waddr_o     = main_q.reg_waddr;
  assign wdate_csr_reg_o = main_q.wdate_csr_reg;
  // Side-effecting enables are masked so a bubble never acts.
  assign ram_we_o        = main_q.ram_we & main_valid_q;
  assign ram_re_o        = main_q.ram_re & main_valid_q;
  assign reg_we_o        = main_q.reg_we & main_valid_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !out_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (main_valid_q || skid_valid_q || in_valid)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
